// File: rtl/wav_pkg.sv
// Shared WAV/RIFF constants, state encoding and byte-select helpers.
// Purely declarative; no latency.
// No flow control of its own; used by both the writer and the parser.
package wav_pkg;

  localparam int unsigned WAV_HEADER_BYTES = 44;

  // Chunk IDs as they appear in the file: first character in the top byte.
  localparam logic [31:0] RIFF_ID = 32'h5249_4646; // "RIFF"
  localparam logic [31:0] WAVE_ID = 32'h5741_5645; // "WAVE"
  localparam logic [31:0] FMT_ID  = 32'h666D_7420; // "fmt "
  localparam logic [31:0] DATA_ID = 32'h6461_7461; // "data"

  localparam logic [31:0] FMT_CHUNK_SIZE = 32'd16;
  localparam logic [15:0] WAV_FMT_PCM    = 16'd1;
  localparam logic [15:0] WAV_CHANNELS   = 16'd1;
  localparam logic [15:0] WAV_BLOCK_ALGN = 16'd1;
  localparam logic [15:0] WAV_BITS_PER_S = 16'd8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    DATA   = 2'd2,
    FLUSH  = 2'd3
  } wav_state_e;

  // Byte k of a little-endian numeric field (k=0 is the LSB, sent first).
  function automatic logic [7:0] le_byte(input logic [31:0] v, input logic [1:0] k);
    return v[{k, 3'b000} +: 8];
  endfunction

  // Byte k of a four-character chunk ID (k=0 is the first character).
  function automatic logic [7:0] id_byte(input logic [31:0] id, input logic [1:0] k);
    return id[{~k, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/wav_stream_writer_header_rom.sv
// Combinational lookup of one byte of the canonical 44-byte WAV header.
// Zero latency: the byte follows idx_i/num_samples_i in the same cycle.
// No handshake; the caller decides when to sample the output.
module wav_header_rom
  import wav_pkg::*;
#(
  parameter int unsigned SAMPLE_RATE = 8000
) (
  input  logic [5:0]  idx_i,
  input  logic [31:0] num_samples_i,
  output logic [7:0]  hdr_byte_o
);

  localparam logic [31:0] RATE_W = 32'(SAMPLE_RATE);

  logic [31:0] riff_size;
  logic [1:0]  k;

  // Select the header word by idx[5:2] and the byte within it by idx[1:0].
  always_comb begin
    riff_size  = 32'd36 + num_samples_i;
    k          = idx_i[1:0];
    hdr_byte_o = 8'h00;
    case (idx_i[5:2])
      4'd0:    hdr_byte_o = id_byte(RIFF_ID, k);
      4'd1:    hdr_byte_o = le_byte(riff_size, k);
      4'd2:    hdr_byte_o = id_byte(WAVE_ID, k);
      4'd3:    hdr_byte_o = id_byte(FMT_ID, k);
      4'd4:    hdr_byte_o = le_byte(FMT_CHUNK_SIZE, k);
      4'd5:    hdr_byte_o = le_byte({WAV_CHANNELS, WAV_FMT_PCM}, k);
      4'd6:    hdr_byte_o = le_byte(RATE_W, k);
      4'd7:    hdr_byte_o = le_byte(RATE_W, k); // byte rate == sample rate for 8-bit mono
      4'd8:    hdr_byte_o = le_byte({WAV_BITS_PER_S, WAV_BLOCK_ALGN}, k);
      4'd9:    hdr_byte_o = id_byte(DATA_ID, k);
      4'd10:   hdr_byte_o = le_byte(num_samples_i, k);
      default: hdr_byte_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/wav_stream_writer.sv
// WAV byte-stream encoder: 44-byte RIFF header then N sample bytes, 1 byte/transfer.
// First header byte valid the cycle after start; samples pass through with 1 cycle latency.
// Single output register stage; sample_ready_out follows sink readiness while in DATA.
module wav_stream_writer
  import wav_pkg::*;
#(
  parameter int unsigned SAMPLE_RATE = 8000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        start_in,
  input  logic [31:0] num_samples_in,
  input  logic [7:0]  sample_in,
  input  logic        sample_valid_in,
  output logic        sample_ready_out,
  output logic [7:0]  wavbyte_out,
  output logic        wavbyte_valid_out,
  input  logic        wavbyte_ready_in,
  output logic        busy_out,
  output logic        done_out
);

  wav_state_e  state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic [31:0] n_q, n_d;
  logic [31:0] cnt_q, cnt_d;
  logic [7:0]  byte_q, byte_d;
  logic        vld_q, vld_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        can_load;
  logic [5:0]  rom_idx;
  logic [31:0] rom_n;
  logic [7:0]  rom_byte;

  // The output register accepts a new byte when empty or draining this cycle.
  assign can_load = !vld_q || wavbyte_ready_in;

  // In IDLE the ROM is driven with byte 0 so the first header byte can be
  // loaded on the start cycle itself.
  assign rom_idx = (state_q == IDLE) ? 6'd0 : idx_q;
  assign rom_n   = (state_q == IDLE) ? num_samples_in : n_q;

  wav_header_rom #(
    .SAMPLE_RATE (SAMPLE_RATE)
  ) u_hdr_rom (
    .idx_i         (rom_idx),
    .num_samples_i (rom_n),
    .hdr_byte_o    (rom_byte)
  );

  // Next-state, output-register load and handshake decode.
  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    n_d              = n_q;
    cnt_d            = cnt_q;
    byte_d           = byte_q;
    vld_d            = vld_q && !wavbyte_ready_in;
    busy_d           = busy_q;
    done_d           = 1'b0;
    sample_ready_out = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_in) begin
          n_d     = num_samples_in;
          byte_d  = rom_byte;
          vld_d   = 1'b1;
          idx_d   = 6'd1;
          busy_d  = 1'b1;
          state_d = HEADER;
        end
      end
      HEADER: begin
        if (can_load) begin
          byte_d = rom_byte;
          vld_d  = 1'b1;
          idx_d  = idx_q + 6'd1;
          if (idx_q == 6'(WAV_HEADER_BYTES - 1)) begin
            cnt_d   = n_q;
            state_d = (n_q != 32'd0) ? DATA : FLUSH;
          end
        end
      end
      DATA: begin
        sample_ready_out = can_load;
        if (sample_valid_in && can_load) begin
          byte_d = sample_in;
          vld_d  = 1'b1;
          cnt_d  = cnt_q - 32'd1;
          if (cnt_q == 32'd1) begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (!vld_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any partial file silently.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      idx_q   <= 6'd0;
      n_q     <= 32'd0;
      cnt_q   <= 32'd0;
      byte_q  <= 8'h00;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      byte_q  <= byte_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign wavbyte_out       = byte_q;
  assign wavbyte_valid_out = vld_q;
  assign busy_out          = busy_q;
  assign done_out          = done_q;

endmodule

// File: tb/tb_wav_stream_writer.sv
// Scoreboard bench for wav_stream_writer: stimulus pushes expected bytes,
// a negedge monitor pops them on every accepted output transfer.
// Sink readiness is either constant or LFSR-driven.
`timescale 1ns/1ps
module tb_wav_stream_writer;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        start_in = 1'b0;
  logic [31:0] num_samples_in = 32'd0;
  logic [7:0]  sample_in = 8'h00;
  logic        sample_valid_in = 1'b0;
  logic        sample_ready_out;
  logic [7:0]  wavbyte_out;
  logic        wavbyte_valid_out;
  logic        wavbyte_ready_in = 1'b1;
  logic        busy_out;
  logic        done_out;

  wav_stream_writer #(.SAMPLE_RATE(8000)) dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .start_in          (start_in),
    .num_samples_in    (num_samples_in),
    .sample_in         (sample_in),
    .sample_valid_in   (sample_valid_in),
    .sample_ready_out  (sample_ready_out),
    .wavbyte_out       (wavbyte_out),
    .wavbyte_valid_out (wavbyte_valid_out),
    .wavbyte_ready_in  (wavbyte_ready_in),
    .busy_out          (busy_out),
    .done_out          (done_out)
  );

  always #5 clk_in = ~clk_in;

  logic [7:0]  exp_q[$];
  logic [7:0]  smp[256];
  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  bit          srdy_seen = 1'b0;
  bit          rnd_ready = 1'b0;
  logic [15:0] lfsr = 16'hACE1;
  bit          prev_stall = 1'b0;
  logic [7:0]  held = 8'h00;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic push_le32(input logic [31:0] v);
    exp_q.push_back(v[7:0]);   exp_q.push_back(v[15:8]);
    exp_q.push_back(v[23:16]); exp_q.push_back(v[31:24]);
  endtask

  task automatic push_le16(input logic [15:0] v);
    exp_q.push_back(v[7:0]); exp_q.push_back(v[15:8]);
  endtask

  task automatic push_id(input logic [31:0] v);
    exp_q.push_back(v[31:24]); exp_q.push_back(v[23:16]);
    exp_q.push_back(v[15:8]);  exp_q.push_back(v[7:0]);
  endtask

  task automatic push_header(input logic [31:0] n);
    push_id("RIFF"); push_le32(32'd36 + n); push_id("WAVE"); push_id("fmt ");
    push_le32(32'd16); push_le16(16'd1); push_le16(16'd1);
    push_le32(32'd8000); push_le32(32'd8000); push_le16(16'd1); push_le16(16'd8);
    push_id("data"); push_le32(n);
  endtask

  // Sink readiness, updated just after each rising edge.
  initial begin
    forever begin
      @(posedge clk_in); #1;
      lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      wavbyte_ready_in = rnd_ready ? lfsr[0] : 1'b1;
    end
  end

  // Monitor: compare every accepted byte, output hold stability, done timing.
  always @(negedge clk_in) begin
    if (rst_in) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", wavbyte_valid_out, 1);
        chk("hold_byte", wavbyte_out, held);
      end
      if (wavbyte_valid_out && wavbyte_ready_in) begin
        if (exp_q.size() == 0) chk("extra_byte", 1, 0);
        else chk("stream_byte", wavbyte_out, exp_q.pop_front());
      end
      prev_stall = wavbyte_valid_out && !wavbyte_ready_in;
      held       = wavbyte_out;
      if (sample_ready_out) srdy_seen = 1'b1;
      if (done_out) begin
        done_cnt++;
        chk("bytes_left_at_done", exp_q.size(), 0);
      end
    end
  end

  task automatic start_file(input logic [31:0] n);
    @(posedge clk_in); #1;
    num_samples_in = n; start_in = 1'b1;
    @(posedge clk_in); #1;
    start_in = 1'b0; num_samples_in = 32'hDEAD_BEEF;
    @(negedge clk_in);
    chk("first_byte_valid", wavbyte_valid_out, 1);
    chk("busy_after_start", busy_out, 1);
    @(posedge clk_in); #1;
  endtask

  task automatic feed(input int n);
    for (int k = 0; k < n; k++) begin
      bit acc;
      int guard;
      acc = 1'b0; guard = 0;
      sample_in = smp[k]; sample_valid_in = 1'b1;
      while (!acc && guard < 1000) begin
        @(negedge clk_in); acc = sample_ready_out;
        @(posedge clk_in); #1; guard++;
      end
      if (!acc) begin
        chk("sample_accept_timeout", 0, 1);
        sample_valid_in = 1'b0;
        return;
      end
    end
    sample_valid_in = 1'b0;
  endtask

  task automatic wait_done();
    int d0;
    int guard;
    d0 = done_cnt; guard = 0;
    while (done_cnt == d0 && guard < 2000) begin
      @(posedge clk_in); guard++;
    end
    chk("done_seen", done_cnt - d0, 1);
    repeat (3) @(posedge clk_in);
    #1;
    chk("done_single_pulse", done_cnt - d0, 1);
    chk("busy_fell", busy_out, 0);
  endtask

  initial begin
    logic [7:0] t1[48];
    int d0;
    t1 = '{8'h52, 8'h49, 8'h46, 8'h46, 8'h28, 8'h00, 8'h00, 8'h00,
           8'h57, 8'h41, 8'h56, 8'h45, 8'h66, 8'h6D, 8'h74, 8'h20,
           8'h10, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00,
           8'h40, 8'h1F, 8'h00, 8'h00, 8'h40, 8'h1F, 8'h00, 8'h00,
           8'h01, 8'h00, 8'h08, 8'h00, 8'h64, 8'h61, 8'h74, 8'h61,
           8'h04, 8'h00, 8'h00, 8'h00, 8'h10, 8'h20, 8'h30, 8'h40};

    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    chk("rst_valid", wavbyte_valid_out, 0);
    chk("rst_byte", wavbyte_out, 0);
    chk("rst_sready", sample_ready_out, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_done", done_out, 0);
    @(posedge clk_in); #1; rst_in = 1'b0;

    // N=4, hand-computed 48-byte file.
    for (int i = 0; i < 48; i++) exp_q.push_back(t1[i]);
    smp[0] = 8'h10; smp[1] = 8'h20; smp[2] = 8'h30; smp[3] = 8'h40;
    start_file(32'd4); feed(4); wait_done();

    // N=0: header only, sample port never ready.
    srdy_seen = 1'b0;
    push_header(32'd0);
    sample_in = 8'h77; sample_valid_in = 1'b1;
    start_file(32'd0); wait_done();
    sample_valid_in = 1'b0;
    chk("n0_sready_never", srdy_seen, 0);

    // N=3 with a random-ready sink.
    rnd_ready = 1'b1;
    smp[0] = 8'hA5; smp[1] = 8'h5A; smp[2] = 8'hC3;
    push_header(32'd3);
    for (int i = 0; i < 3; i++) exp_q.push_back(smp[i]);
    start_file(32'd3); feed(3); wait_done();
    rnd_ready = 1'b0;

    // N=256 ramp, as the loopback parser would see it.
    for (int i = 0; i < 256; i++) smp[i] = 8'(i);
    push_header(32'd256);
    for (int i = 0; i < 256; i++) exp_q.push_back(smp[i]);
    start_file(32'd256); feed(256); wait_done();

    // Reset after 2 of 8 samples: outputs clear, no done, then a fresh file.
    for (int i = 0; i < 8; i++) smp[i] = 8'(8'hE0 + i);
    push_header(32'd8);
    for (int i = 0; i < 8; i++) exp_q.push_back(smp[i]);
    start_file(32'd8); feed(2);
    d0 = done_cnt;
    rst_in = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    chk("midrst_valid", wavbyte_valid_out, 0);
    chk("midrst_byte", wavbyte_out, 0);
    chk("midrst_sready", sample_ready_out, 0);
    chk("midrst_busy", busy_out, 0);
    chk("midrst_done", done_out, 0);
    @(posedge clk_in); #1; rst_in = 1'b0;
    exp_q.delete();
    repeat (60) @(posedge clk_in);
    chk("midrst_no_done", done_cnt - d0, 0);
    smp[0] = 8'h3C; smp[1] = 8'hC3;
    push_header(32'd2); exp_q.push_back(8'h3C); exp_q.push_back(8'hC3);
    start_file(32'd2); feed(2); wait_done();

    // Second start mid-header with a different N must be ignored.
    for (int i = 0; i < 5; i++) smp[i] = 8'(8'h50 + i);
    push_header(32'd5);
    for (int i = 0; i < 5; i++) exp_q.push_back(smp[i]);
    start_file(32'd5);
    repeat (10) @(posedge clk_in);
    #1; num_samples_in = 32'd9; start_in = 1'b1;
    @(posedge clk_in); #1; start_in = 1'b0;
    feed(5); wait_done();
    repeat (60) @(posedge clk_in);
    chk("restart_ignored_idle", busy_out, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
